// File: rtl/vc_test_pkg.sv
// Shared types and constants for the val/rdy test source and the random-delay helpers.
package vc_test_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } src_state_e;

  localparam int unsigned c_lfsr_nbits = 16;
  // Galois taps for x^16+x^14+x^13+x^11+1
  localparam logic [c_lfsr_nbits-1:0] c_lfsr_taps = 16'hB400;

endpackage

// File: rtl/vc_EnResetReg.sv
// Enabled register with asynchronous active-high reset to a parameterised value.
module vc_EnResetReg #(
  parameter int unsigned         p_nbits       = 1,
  parameter logic [p_nbits-1:0]  p_reset_value = '0
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [p_nbits-1:0] d,
  output logic [p_nbits-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= p_reset_value;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/vc_lfsr16.sv
// 16-bit right-shifting Galois LFSR; steps on every enabled clock, reloads seed on reset.
module vc_lfsr16
  import vc_test_pkg::*;
#(
  parameter logic [c_lfsr_nbits-1:0] seed = 16'hB5AD
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  output logic [c_lfsr_nbits-1:0] q
);

  logic [c_lfsr_nbits-1:0] lfsr_d;

  always_comb begin
    lfsr_d = q >> 1;
    if (q[0]) begin
      lfsr_d = (q >> 1) ^ c_lfsr_taps;
    end else begin
      lfsr_d = q >> 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= seed;
    end else if (en) begin
      q <= lfsr_d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/vc_test_rand_delay_source.sv
// Test source: replays m[] over val/rdy with an LFSR-drawn idle gap before each message.
// Optional protocol self-checks are compiled in with VC_TEST_SOURCE_ASSERT_EN.
module vc_test_rand_delay_source
  import vc_test_pkg::*;
#(
  parameter int unsigned             p_msg_nbits = 1,
  parameter int unsigned             p_num_msgs  = 1024,
  parameter int unsigned             p_max_delay = 0,
  parameter logic [c_lfsr_nbits-1:0] p_lfsr_seed = 16'hB5AD
)(
  input  logic                   clk,
  input  logic                   reset,
  output logic                   val,
  input  logic                   rdy,
  output logic [p_msg_nbits-1:0] msg,
  output logic                   done
);

  localparam int unsigned c_index_nbits = $clog2(p_num_msgs);
  localparam int unsigned c_delay_nbits = (p_max_delay > 0) ? $clog2(p_max_delay + 1) : 1;

  logic [p_msg_nbits-1:0] m [p_num_msgs-1:0];

  src_state_e               state_q, state_d;
  logic [c_delay_nbits-1:0] delay_cnt_q, delay_cnt_d;
  logic [c_index_nbits-1:0] index_s;
  logic [c_lfsr_nbits-1:0]  lfsr_s;
  logic [c_delay_nbits-1:0] draw_s;
  logic                     xfer_s;
  logic                     last_s;

  vc_lfsr16 #(.seed(p_lfsr_seed)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .q     (lfsr_s)
  );

  vc_EnResetReg #(.p_nbits(c_index_nbits), .p_reset_value('0)) u_index (
    .clk   (clk),
    .reset (reset),
    .en    (xfer_s),
    .d     (index_s + c_index_nbits'(1)),
    .q     (index_s)
  );

  // With p_max_delay = 0 the modulus is 1, so the draw folds to a constant zero
  assign draw_s = c_delay_nbits'({16'b0, lfsr_s} % 32'(p_max_delay + 1));
  assign xfer_s = val && rdy;
  assign last_s = (index_s == c_index_nbits'(p_num_msgs - 1));

  assign val  = (state_q == SEND);
  assign done = (state_q == DONE);
  assign msg  = m[index_s];

  always_comb begin
    state_d     = state_q;
    delay_cnt_d = delay_cnt_q;
    case (state_q)
      IDLE: begin
        if (draw_s == '0) begin
          state_d = SEND;
        end else begin
          state_d     = DELAY;
          delay_cnt_d = draw_s;
        end
      end
      DELAY: begin
        delay_cnt_d = delay_cnt_q - c_delay_nbits'(1);
        if (delay_cnt_q == c_delay_nbits'(1)) begin
          state_d = SEND;
        end else begin
          state_d = DELAY;
        end
      end
      SEND: begin
        if (!xfer_s) begin
          state_d = SEND;
        end else if (last_s) begin
          state_d = DONE;
        end else if (draw_s == '0) begin
          state_d = SEND;
        end else begin
          state_d     = DELAY;
          delay_cnt_d = draw_s;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      delay_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      delay_cnt_q <= delay_cnt_d;
    end
  end

`ifdef VC_TEST_SOURCE_ASSERT_EN
`ifndef VC_ASSERT_NOT_X
`define VC_ASSERT_NOT_X(sig, name) \
  if ($isunknown(sig)) begin \
    $display("%m: expected known value on %s, actual %b", name, sig); \
    $finish; \
  end
`endif

  logic                   val_prev_q;
  logic                   rdy_prev_q;
  logic [p_msg_nbits-1:0] msg_prev_q;

  // Once offered, a message must stay valid and unchanged until it is taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_prev_q <= 1'b0;
      rdy_prev_q <= 1'b0;
      msg_prev_q <= '0;
    end else begin
      `VC_ASSERT_NOT_X(rdy, "rdy")
      if (val_prev_q && !rdy_prev_q && (!val || (msg != msg_prev_q))) begin
        $display("%m: stalled message changed, expected val=1 msg=%h, actual val=%b msg=%h",
                 msg_prev_q, val, msg);
        $finish;
      end
      val_prev_q <= val;
      rdy_prev_q <= rdy;
      msg_prev_q <= msg;
    end
  end
`endif

endmodule

// File: tb/tb_vc_test_rand_delay_source.sv
// Directed bench: back-to-back replay, backpressure, async reset mid-stream and in DONE,
// and LFSR-driven gaps with a hand-computed send schedule for seed 16'hB5AD.
module tb_vc_test_rand_delay_source;

  logic       clk = 1'b0;
  logic       reset0, reset1;
  logic       rdy0, rdy1;
  logic       val0, val1;
  logic       done0, done1;
  logic [7:0] msg0, msg1;

  int n_checks = 0;
  int n_errors = 0;

  // 0: idle (val=0, done=0); -1: done; otherwise val=1 with that message
  int exp_tab [10];
  // rdy stays high, seed 16'hB5AD, p_max_delay=3: draws 1,3,2,2,3,2,3,1
  int send_cyc [8] = '{2, 6, 9, 12, 16, 19, 23, 25};

  always #5 clk = ~clk;

  vc_test_rand_delay_source #(
    .p_msg_nbits(8), .p_num_msgs(4), .p_max_delay(0), .p_lfsr_seed(16'hB5AD)
  ) dut0 (
    .clk(clk), .reset(reset0), .val(val0), .rdy(rdy0), .msg(msg0), .done(done0)
  );

  vc_test_rand_delay_source #(
    .p_msg_nbits(8), .p_num_msgs(8), .p_max_delay(3), .p_lfsr_seed(16'hB5AD)
  ) dut1 (
    .clk(clk), .reset(reset1), .val(val1), .rdy(rdy1), .msg(msg1), .done(done1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered #1 after the edge that follows reset release; cycle c is sampled on its negedge
  task automatic run_stream0(input int ncyc, input int stall_lo, input int stall_hi);
    for (int c = 0; c < ncyc; c++) begin
      rdy0 = (c >= stall_lo && c <= stall_hi) ? 1'b0 : 1'b1;
      @(negedge clk);
      check_eq($sformatf("val0 c%0d", c), {31'b0, val0}, {31'b0, (exp_tab[c] > 0)});
      check_eq($sformatf("done0 c%0d", c), {31'b0, done0}, {31'b0, (exp_tab[c] < 0)});
      if (exp_tab[c] > 0) begin
        check_eq($sformatf("msg0 c%0d", c), {24'b0, msg0}, 32'(exp_tab[c]));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_reset0();
    @(posedge clk);
    #1 reset0 = 1'b0;
  endtask

  task automatic run_stream1(input string run);
    int k = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (k < 8 && c == send_cyc[k]) begin
        check_eq($sformatf("%s val1 c%0d", run, c), {31'b0, val1}, 32'd1);
        check_eq($sformatf("%s msg1 c%0d", run, c), {24'b0, msg1}, 32'(8'hA0 + k));
        k++;
      end else begin
        check_eq($sformatf("%s val1 c%0d", run, c), {31'b0, val1}, 32'd0);
      end
      check_eq($sformatf("%s done1 c%0d", run, c), {31'b0, done1}, {31'b0, (c >= 26)});
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset0 = 1'b1;
    reset1 = 1'b1;
    rdy0   = 1'b1;
    rdy1   = 1'b1;
    dut0.m[0] = 8'h11;
    dut0.m[1] = 8'h22;
    dut0.m[2] = 8'h33;
    dut0.m[3] = 8'h44;
    for (int i = 0; i < 8; i++) dut1.m[i] = 8'(8'hA0 + i);

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset val0", {31'b0, val0}, 32'd0);
    check_eq("reset done0", {31'b0, done0}, 32'd0);
    check_eq("reset msg0", {24'b0, msg0}, 32'h11);

    // back-to-back replay
    exp_tab = '{0, 'h11, 'h22, 'h33, 'h44, -1, -1, -1, -1, -1};
    release_reset0();
    run_stream0(7, -1, -2);

    // backpressure while 22 is offered
    reset0 = 1'b1;
    release_reset0();
    exp_tab = '{0, 'h11, 'h22, 'h22, 'h22, 'h22, 'h33, 'h44, -1, -1};
    run_stream0(10, 2, 4);

    // async reset after two messages, while 33 is on the bus
    reset0 = 1'b1;
    release_reset0();
    exp_tab = '{0, 'h11, 'h22, 'h33, 'h44, -1, -1, -1, -1, -1};
    run_stream0(3, -1, -2);
    check_eq("mid msg0 before reset", {24'b0, msg0}, 32'h33);
    reset0 = 1'b1;
    #1;
    check_eq("mid reset val0", {31'b0, val0}, 32'd0);
    check_eq("mid reset done0", {31'b0, done0}, 32'd0);
    check_eq("mid reset msg0", {24'b0, msg0}, 32'h11);
    release_reset0();
    run_stream0(7, -1, -2);

    // async reset while in DONE, then a full replay
    reset0 = 1'b1;
    #1;
    check_eq("done reset done0", {31'b0, done0}, 32'd0);
    check_eq("done reset val0", {31'b0, val0}, 32'd0);
    release_reset0();
    run_stream0(7, -1, -2);

    // random gaps: same schedule on two runs from the same seed
    @(posedge clk);
    #1 reset1 = 1'b0;
    run_stream1("run1");
    reset1 = 1'b1;
    @(posedge clk);
    #1 reset1 = 1'b0;
    run_stream1("run2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
